// File: rtl/score_draw_pkg.sv
// Shared constants, FSM state type and the double-dabble adjust step for score_draw.
package score_draw_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int DIGITS  = 4;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int BIN_W   = 12;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } conv_state_e;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/score_draw_digit_font_rom.sv
// 8x16 glyphs for digits 0-9, one registered row per cycle; other codes read blank.
module digit_font_rom
  import score_draw_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] digit,
  input  logic [3:0] row,
  output logic [7:0] row_bits
);

  logic [GLYPH_W*GLYPH_H-1:0] glyph;
  logic [7:0]                 row_bits_d;

  // Glyph lookup; row 0 is the most significant byte.
  always_comb begin
    glyph = '0;
    case (digit)
      4'd0: glyph = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
      4'd1: glyph = 128'h00001838781818181818187E00000000;
      4'd2: glyph = 128'h00007CC6060C183060C0C6FE00000000;
      4'd3: glyph = 128'h00007CC606063C060606C67C00000000;
      4'd4: glyph = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      4'd5: glyph = 128'h0000FEC0C0C0FC060606C67C00000000;
      4'd6: glyph = 128'h00003860C0C0FCC6C6C6C67C00000000;
      4'd7: glyph = 128'h0000FEC606060C183030303000000000;
      4'd8: glyph = 128'h00007CC6C6C67CC6C6C6C67C00000000;
      4'd9: glyph = 128'h00007CC6C6C67E0606060C7800000000;
      default: glyph = '0;
    endcase
    row_bits_d = glyph[{~row, 3'b000} +: 8];
  end

  // Row output register.
  always_ff @(posedge clk) begin
    row_bits <= row_bits_d;
  end

endmodule

// File: rtl/score_draw.sv
// Four-digit decimal survival-time overlay: per-frame double-dabble conversion
// plus a 2-cycle pixel pipeline with matched sync/blank delay.
module score_draw
  import score_draw_pkg::*;
#(
  parameter logic [10:0] SCORE_X    = 11'd16,
  parameter logic [9:0]  SCORE_Y    = 10'd16,
  parameter int          SCALE_LOG2 = 1,
  parameter logic [11:0] FG_COLOR   = 12'hFFF
) (
  input  logic        system_clock_in,
  input  logic        system_reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [11:0] time_alive,
  output logic [11:0] rgb,
  output logic        pixel_on,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic [15:0] bcd_out,
  output logic        bcd_valid
);

  localparam int CELL_SHIFT = 3 + SCALE_LOG2;
  localparam int BOX_W      = DIGITS * (GLYPH_W << SCALE_LOG2);
  localparam int BOX_H      = GLYPH_H << SCALE_LOG2;

  // ---------------------------------------------------------------------------
  // Binary-to-BCD conversion engine
  // ---------------------------------------------------------------------------
  conv_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       acc_q, acc_d;
  logic [BCD_W-1:0]       bcd_out_q, bcd_out_d;
  logic                   bcd_valid_q, bcd_valid_d;
  logic [BCD_W+BIN_W-1:0] shift_w;
  logic                   start;

  assign start   = (hcount == 11'd1) && (vcount == 10'd1);
  assign shift_w = {dabble_adjust(acc_q), bin_q} << 1;

  // Next-state and datapath for the conversion FSM. The result is loaded on the
  // final shift so bcd_out and bcd_valid are both visible during DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = time_alive;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {acc_d, bin_d} = shift_w;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_out_d   = shift_w[BCD_W+BIN_W-1 -: BCD_W];
          bcd_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion control and published result.
  always_ff @(posedge system_clock_in) begin
    if (system_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bcd_out_q   <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  // Shift-register and accumulator data, reloaded at every start.
  always_ff @(posedge system_clock_in) begin
    bin_q <= bin_d;
    acc_q <= acc_d;
  end

  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: box decode, digit select, leading-zero suppression, ROM address
  // ---------------------------------------------------------------------------
  logic [10:0] dx, dy;
  logic [1:0]  digit_idx;
  logic [2:0]  glyph_col;
  logic [3:0]  glyph_row;
  logic [3:0]  nibble;
  logic        in_box_p1_d, suppress_p1_d;
  logic        in_box_p1_q, suppress_p1_q;
  logic [2:0]  col_p1_q;
  logic [7:0]  row_bits_p1;
  logic        hs_p1_q, vs_p1_q, bl_p1_q;

  // Raster-to-glyph mapping for the current pixel.
  always_comb begin
    dx          = hcount - SCORE_X;
    dy          = {1'b0, vcount} - {1'b0, SCORE_Y};
    in_box_p1_d = (hcount >= SCORE_X) && (dx < 11'(BOX_W)) &&
                  (vcount >= SCORE_Y) && (dy < 11'(BOX_H)) && !blank;
    digit_idx   = dx[CELL_SHIFT+1 : CELL_SHIFT];
    glyph_col   = dx[SCALE_LOG2+2 : SCALE_LOG2];
    glyph_row   = dy[SCALE_LOG2+3 : SCALE_LOG2];
    nibble      = bcd_out_q[{~digit_idx, 2'b00} +: 4];
    case (digit_idx)
      2'd0:    suppress_p1_d = (bcd_out_q[15:12] == 4'd0);
      2'd1:    suppress_p1_d = (bcd_out_q[15:8] == 8'd0);
      2'd2:    suppress_p1_d = (bcd_out_q[15:4] == 12'd0);
      default: suppress_p1_d = 1'b0;
    endcase
  end

  digit_font_rom u_font (
    .clk      (system_clock_in),
    .digit    (nibble),
    .row      (glyph_row),
    .row_bits (row_bits_p1)
  );

  // Stage 1 control registers.
  always_ff @(posedge system_clock_in) begin
    if (system_reset) begin
      in_box_p1_q <= 1'b0;
      hs_p1_q     <= 1'b0;
      vs_p1_q     <= 1'b0;
      bl_p1_q     <= 1'b0;
    end else begin
      in_box_p1_q <= in_box_p1_d;
      hs_p1_q     <= hsync;
      vs_p1_q     <= vsync;
      bl_p1_q     <= blank;
    end
  end

  // Stage 1 data registers.
  always_ff @(posedge system_clock_in) begin
    suppress_p1_q <= suppress_p1_d;
    col_p1_q      <= glyph_col;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: glyph bit pick and colour
  // ---------------------------------------------------------------------------
  logic        pixel_on_p2_d, pixel_on_p2_q;
  logic [11:0] rgb_p2_d, rgb_p2_q;
  logic        hs_p2_q, vs_p2_q, bl_p2_q;

  // Lit-pixel decision from the ROM row.
  always_comb begin
    pixel_on_p2_d = in_box_p1_q && !suppress_p1_q && row_bits_p1[3'd7 - col_p1_q];
    rgb_p2_d      = pixel_on_p2_d ? FG_COLOR : 12'h000;
  end

  // Stage 2 output registers.
  always_ff @(posedge system_clock_in) begin
    if (system_reset) begin
      pixel_on_p2_q <= 1'b0;
      rgb_p2_q      <= 12'h000;
      hs_p2_q       <= 1'b0;
      vs_p2_q       <= 1'b0;
      bl_p2_q       <= 1'b0;
    end else begin
      pixel_on_p2_q <= pixel_on_p2_d;
      rgb_p2_q      <= rgb_p2_d;
      hs_p2_q       <= hs_p1_q;
      vs_p2_q       <= vs_p1_q;
      bl_p2_q       <= bl_p1_q;
    end
  end

  assign pixel_on  = pixel_on_p2_q;
  assign rgb       = rgb_p2_q;
  assign hsync_out = hs_p2_q;
  assign vsync_out = vs_p2_q;
  assign blank_out = bl_p2_q;

endmodule
